// File: rtl/step_core.sv
// Multi-cycle accumulator core: fetches 16-bit instructions from shared memory over a
// req/ack handshake, executes them against acc/dp/pc and writes results back.
module step_core #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 15,
    parameter int START_ADDR = 9216,
    parameter int DATA_WRAP  = 8000,
    parameter int TICK_DIV   = 11
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [ADDR_W-1:0] PC_BASE = ADDR_W'(START_ADDR);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  tcnt;
    logic              tick;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [ADDR_W-1:0] dp, dp_nx;
    logic [DATA_W-1:0] acc, acc_nx;
    logic [15:0]       instr, instr_nx;
    logic [3:0]        op;
    logic [11:0]       imm;
    logic              req_c, we_c;

    // Only the JUMP increment is bounded; SETDP may load any value.
    function automatic logic [ADDR_W-1:0] dp_jump_step(input logic [ADDR_W-1:0] d);
        logic [ADDR_W:0] n;
        n = {1'b0, d} + (ADDR_W+1)'(1);
        if (n > (ADDR_W+1)'(DATA_WRAP))
            return '0;
        return n[ADDR_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] add_imm(input logic [DATA_W-1:0] a,
                                                  input logic [11:0]       i);
        return a + DATA_W'(i);
    endfunction

    assign op        = instr[15:12];
    assign imm       = instr[11:0];
    assign tick      = (tcnt == CNT_W'(TICK_DIV - 1));
    assign mem_wdata = acc;
    assign pc_dbg    = pc;

    // Reset must force the bus idle immediately, even though the FSM sits in FETCH.
    assign mem_req = req_c & reset_n;
    assign mem_we  = we_c & reset_n;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        dp_nx    = dp;
        acc_nx   = acc;
        instr_nx = instr;
        req_c    = 1'b0;
        we_c     = 1'b0;
        mem_addr = pc;
        halted   = 1'b0;
        case (state)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    instr_nx = mem_rdata[15:0];
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == 4'h0 || op == 4'h1)
                    state_nx = S_MEM;
                else if (op == 4'hF)
                    state_nx = S_HALT;
                else
                    state_nx = S_EXEC;
            end
            S_EXEC: begin
                state_nx = S_FETCH;
                pc_nx    = pc + ADDR_W'(1);
                case (op)
                    4'h2: acc_nx = add_imm(acc, imm);
                    4'h3: begin
                        pc_nx = PC_BASE;
                        dp_nx = dp_jump_step(dp);
                    end
                    4'h4: dp_nx = ADDR_W'(imm);
                    4'h5: if (acc != '0) pc_nx = PC_BASE + ADDR_W'(imm);
                    default: ;
                endcase
            end
            S_MEM: begin
                req_c    = 1'b1;
                we_c     = (op == 4'h1);
                mem_addr = dp;
                if (mem_ack) begin
                    if (op == 4'h0)
                        acc_nx = mem_rdata;
                    pc_nx    = pc + ADDR_W'(1);
                    state_nx = S_FETCH;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
            tcnt  <= '0;
            pc    <= PC_BASE;
            dp    <= '0;
            acc   <= '0;
            instr <= '0;
        end else begin
            tcnt <= tick ? '0 : tcnt + CNT_W'(1);
            if (tick) begin
                state <= state_nx;
                pc    <= pc_nx;
                dp    <= dp_nx;
                acc   <= acc_nx;
                instr <= instr_nx;
            end
        end
    end

endmodule

// File: tb/tb_step_core.sv
// Directed bench for step_core: one instance at TICK_DIV=1/DATA_WRAP=4 with a
// latency-programmable memory, one at TICK_DIV=4 with a zero-wait memory.
module tb_step_core;

    localparam logic [14:0] SA = 15'd9216;

    // {req, we, halted} and addr per cycle for the three-instruction program
    localparam logic [2:0]  T1_CTL  [10] = '{3'b100, 3'b000, 3'b000, 3'b100, 3'b000,
                                             3'b110, 3'b100, 3'b000, 3'b001, 3'b001};
    localparam logic [14:0] T1_ADDR [8]  = '{15'd9216, 15'd9216, 15'd9216, 15'd9217,
                                             15'd9217, 15'd0, 15'd9218, 15'd9218};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_a_n, rst_b_n;
    logic        req_a, we_a, ack_a, halted_a;
    logic [14:0] addr_a, pc_a;
    logic [15:0] wdata_a, rdata_a;
    logic        req_b, we_b, ack_b, halted_b;
    logic [14:0] addr_b, pc_b;
    logic [15:0] wdata_b, rdata_b;

    logic [15:0] mem_a [0:32767];
    logic [15:0] mem_b [0:32767];
    logic        ld_we;
    logic [14:0] ld_addr;
    logic [15:0] ld_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat_a = 0;
    int          cnt_a = 0;
    int          cur_a;
    logic        prev_req_a = 1'b0;
    logic        prev_we_a  = 1'b0;
    logic [14:0] prev_addr_a = '0;

    step_core #(.DATA_W(16), .ADDR_W(15), .START_ADDR(9216), .DATA_WRAP(4), .TICK_DIV(1)) dut_a (
        .clock(clock), .reset_n(rst_a_n), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_rdata(rdata_a), .mem_ack(ack_a), .halted(halted_a), .pc_dbg(pc_a)
    );

    step_core #(.DATA_W(16), .ADDR_W(15), .START_ADDR(9216), .DATA_WRAP(8000), .TICK_DIV(4)) dut_b (
        .clock(clock), .reset_n(rst_b_n), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ack(ack_b), .halted(halted_b), .pc_dbg(pc_b)
    );

    // Memory A acks once a request has been held unchanged for lat_a cycles.
    always_comb begin
        if (req_a && prev_req_a && addr_a == prev_addr_a && we_a == prev_we_a)
            cur_a = cnt_a + 1;
        else
            cur_a = 0;
    end
    assign ack_a   = req_a && (cur_a >= lat_a);
    assign rdata_a = mem_a[addr_a];
    assign ack_b   = req_b;
    assign rdata_b = mem_b[addr_b];

    always @(posedge clock) begin
        if (ld_we)
            mem_a[ld_addr] <= ld_data;
        else if (req_a && we_a && ack_a)
            mem_a[addr_a] <= wdata_a;
        if (ld_we)
            mem_b[ld_addr] <= ld_data;
        else if (req_b && we_b && ack_b)
            mem_b[addr_b] <= wdata_b;
        prev_req_a  <= req_a;
        prev_we_a   <= we_a;
        prev_addr_a <= addr_a;
        cnt_a       <= cur_a;
    end

    task automatic poke(input logic [14:0] a, input logic [15:0] d);
        ld_addr = a;
        ld_data = d;
        ld_we   = 1'b1;
        @(posedge clock);
        #1 ld_we = 1'b0;
    endtask

    task automatic start_a();
        @(negedge clock);
        rst_a_n = 1'b1;
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_halt_a(input int budget, input string tag);
        int k = 0;
        while (halted_a !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        n_cmp++;
        if (halted_a !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_halt: halted=%b after %0d cycles, required 1", tag, halted_a, k);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({req_a, we_a, halted_a, addr_a, pc_a, wdata_a} !== {3'b000, SA, SA, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset_a: req/we/halt=%b%b%b addr=%0d pc=%0d wdata=%h, required 000 9216 9216 0000",
                     req_a, we_a, halted_a, addr_a, pc_a, wdata_a);
        end
        n_cmp++;
        if ({req_b, we_b, halted_b, addr_b, pc_b, wdata_b} !== {3'b000, SA, SA, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset_b: req/we/halt=%b%b%b addr=%0d pc=%0d wdata=%h, required 000 9216 9216 0000",
                     req_b, we_b, halted_b, addr_b, pc_b, wdata_b);
        end
    endtask

    task automatic test_program();
        rst_a_n = 1'b0;
        poke(SA, 16'h2005);
        poke(SA + 15'd1, 16'h1000);
        poke(SA + 15'd2, 16'hF000);
        poke(15'd0, 16'hBEEF);
        start_a();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step(1);
            n_cmp++;
            if ({req_a, we_a, halted_a} !== T1_CTL[c]) begin
                n_bad++;
                $display("FAIL prog_ctl c%0d: req/we/halt=%b%b%b, required %b", c, req_a, we_a, halted_a, T1_CTL[c]);
            end
            if (c < 8) begin
                n_cmp++;
                if (addr_a !== T1_ADDR[c]) begin
                    n_bad++;
                    $display("FAIL prog_addr c%0d: addr=%0d, required %0d", c, addr_a, T1_ADDR[c]);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (wdata_a !== 16'h0005) begin
                    n_bad++;
                    $display("FAIL prog_wdata: wdata=%h, required 0005", wdata_a);
                end
            end
        end
        n_cmp++;
        if (mem_a[0] !== 16'h0005) begin
            n_bad++;
            $display("FAIL prog_mem0: mem[0]=%h, required 0005", mem_a[0]);
        end
    endtask

    task automatic test_addi_wrap();
        rst_a_n = 1'b0;
        poke(SA, 16'h400A);
        poke(SA + 15'd1, 16'h0000);
        poke(SA + 15'd2, 16'h2002);
        poke(SA + 15'd3, 16'h1000);
        poke(SA + 15'd4, 16'hF000);
        poke(15'd10, 16'hFFFF);
        start_a();
        step(6);
        n_cmp++;
        if (wdata_a !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL addi_read: acc=%h, required ffff", wdata_a);
        end
        step(3);
        n_cmp++;
        if (wdata_a !== 16'h0001) begin
            n_bad++;
            $display("FAIL addi_wrap: acc=%h, required 0001", wdata_a);
        end
        wait_halt_a(40, "addi");
        n_cmp++;
        if (mem_a[10] !== 16'h0001) begin
            n_bad++;
            $display("FAIL addi_mem: mem[10]=%h, required 0001", mem_a[10]);
        end
    endtask

    // JNZ skips to the WRITE on the second pass, so the write address reveals dp after JUMP.
    task automatic test_dp_wrap(input logic [11:0] setdp, input int want);
        rst_a_n = 1'b0;
        poke(SA, 16'h5005);
        poke(SA + 15'd1, {4'h4, setdp});
        poke(SA + 15'd2, 16'h2001);
        poke(SA + 15'd3, 16'h3000);
        poke(SA + 15'd4, 16'hF000);
        poke(SA + 15'd5, 16'h1000);
        poke(SA + 15'd6, 16'hF000);
        for (int i = 0; i < 6; i++) poke(15'(i), 16'h00A0 + 16'(i));
        start_a();
        step(11);
        n_cmp++;
        if (pc_a !== SA + 15'd3) begin
            n_bad++;
            $display("FAIL dp%0d_pc_jump: pc=%0d, required 9219", setdp, pc_a);
        end
        step(1);
        n_cmp++;
        if (pc_a !== SA) begin
            n_bad++;
            $display("FAIL dp%0d_pc_base: pc=%0d, required 9216", setdp, pc_a);
        end
        step(3);
        n_cmp++;
        if (pc_a !== SA + 15'd5) begin
            n_bad++;
            $display("FAIL dp%0d_jnz: pc=%0d, required 9221", setdp, pc_a);
        end
        wait_halt_a(40, "dp");
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (mem_a[i] !== ((i == want) ? 16'h0001 : 16'h00A0 + 16'(i))) begin
                n_bad++;
                $display("FAIL dp%0d_mem%0d: got %h, required %h", setdp, i, mem_a[i],
                         (i == want) ? 16'h0001 : 16'h00A0 + 16'(i));
            end
        end
    endtask

    task automatic test_fetch_wait();
        rst_a_n = 1'b0;
        lat_a   = 3;
        poke(SA, 16'h2001);
        poke(SA + 15'd1, 16'hF000);
        start_a();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step(1);
            n_cmp++;
            if ({req_a, we_a, addr_a, pc_a} !== {2'b10, SA, SA}) begin
                n_bad++;
                $display("FAIL wait_hold c%0d: req=%b we=%b addr=%0d pc=%0d, required 1 0 9216 9216",
                         c, req_a, we_a, addr_a, pc_a);
            end
        end
        step(1);
        n_cmp++;
        if ({req_a, pc_a} !== {1'b0, SA}) begin
            n_bad++;
            $display("FAIL wait_decode: req=%b pc=%0d, required 0 9216", req_a, pc_a);
        end
        wait_halt_a(60, "wait");
        n_cmp++;
        if (wdata_a !== 16'h0001) begin
            n_bad++;
            $display("FAIL wait_acc: acc=%h, required 0001", wdata_a);
        end
        lat_a = 0;
    endtask

    task automatic test_tick_div();
        logic        er, eh;
        logic [14:0] ep;
        rst_a_n = 1'b0;
        poke(SA, 16'h2001);
        poke(SA + 15'd1, 16'hF000);
        @(negedge clock);
        rst_b_n = 1'b1;
        #1;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) step(1);
            er = (c < 4) || (c >= 12 && c < 16);
            ep = (c < 12) ? SA : SA + 15'd1;
            eh = (c >= 20);
            n_cmp++;
            if ({req_b, pc_b, halted_b} !== {er, ep, eh}) begin
                n_bad++;
                $display("FAIL tick c%0d: req=%b pc=%0d halt=%b, required %b %0d %b",
                         c, req_b, pc_b, halted_b, er, ep, eh);
            end
            if (c == 11 || c == 12) begin
                n_cmp++;
                if (wdata_b !== ((c == 12) ? 16'h0001 : 16'h0000)) begin
                    n_bad++;
                    $display("FAIL tick_acc c%0d: acc=%h", c, wdata_b);
                end
            end
        end
        rst_b_n = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        rst_a_n = 1'b0;
        poke(SA, 16'h1000);
        poke(SA + 15'd1, 16'hF000);
        poke(15'd0, 16'h5A5A);
        start_a();
        step(2);
        n_cmp++;
        if ({req_a, we_a, addr_a} !== {2'b11, 15'd0}) begin
            n_bad++;
            $display("FAIL rst_mem_state: req=%b we=%b addr=%0d, required 1 1 0", req_a, we_a, addr_a);
        end
        #2 rst_a_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_a, we_a, addr_a, pc_a, wdata_a} !== {2'b00, SA, SA, 16'h0000}) begin
            n_bad++;
            $display("FAIL rst_async: req=%b we=%b addr=%0d pc=%0d wdata=%h, required 0 0 9216 9216 0000",
                     req_a, we_a, addr_a, pc_a, wdata_a);
        end
        step(1);
        n_cmp++;
        if (mem_a[0] !== 16'h5A5A) begin
            n_bad++;
            $display("FAIL rst_nowrite: mem[0]=%h, required 5a5a", mem_a[0]);
        end
        start_a();
        n_cmp++;
        if ({req_a, we_a, addr_a} !== {2'b10, SA}) begin
            n_bad++;
            $display("FAIL rst_restart: req=%b we=%b addr=%0d, required 1 0 9216", req_a, we_a, addr_a);
        end
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        step(2);
        test_reset();
        test_program();
        test_addi_wrap();
        test_dp_wrap(12'd4, 0);
        test_dp_wrap(12'd3, 4);
        test_fetch_wait();
        test_tick_div();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
